// File: rtl/car_sprite_mapper.sv
// Per-frame pose consumer: snapshots both cars' poses, quantizes the angles to 24 sprite
// directions, and places car2 on a screen whose camera is centred on car1.
module car_sprite_mapper #(
  parameter int ANG_W    = 10,
  parameter int MAP_H_W  = 12,
  parameter int MAP_V_W  = 12,
  parameter int SCR_W    = 640,
  parameter int SCR_H    = 480,
  parameter int SPR_HALF = 32
) (
  input  logic                 i_render_clk,
  input  logic                 i_rst,
  input  logic                 i_frame_start,
  input  logic [ANG_W-1:0]     i_car1_angle,
  input  logic [ANG_W-1:0]     i_car2_angle,
  input  logic [MAP_H_W-1:0]   i_car1_x,
  input  logic [MAP_V_W-1:0]   i_car1_y,
  input  logic [MAP_H_W-1:0]   i_car2_x,
  input  logic [MAP_V_W-1:0]   i_car2_y,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [4:0]           o_car1_dir,
  output logic [4:0]           o_car2_dir,
  output logic [MAP_H_W:0]     o_car2_sx,
  output logic [MAP_V_W:0]     o_car2_sy,
  output logic                 o_car2_vis,
  output logic                 o_busy,
  output logic                 o_drop
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_NORM  = 3'd2;
  localparam logic [2:0] S_DIV   = 3'd3;
  localparam logic [2:0] S_POS   = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  localparam int AW = ANG_W + 2;
  localparam logic signed [AW-1:0] A360 = AW'(360);
  localparam logic signed [AW-1:0] A7   = AW'(7);
  localparam logic [AW-1:0]        R15  = AW'(15);

  localparam logic signed [MAP_H_W:0] HALF_W = (MAP_H_W+1)'(SCR_W / 2);
  localparam logic signed [MAP_V_W:0] HALF_H = (MAP_V_W+1)'(SCR_H / 2);
  localparam logic signed [MAP_H_W:0] SX_LO  = (MAP_H_W+1)'(-SPR_HALF);
  localparam logic signed [MAP_H_W:0] SX_HI  = (MAP_H_W+1)'(SCR_W + SPR_HALF);
  localparam logic signed [MAP_V_W:0] SY_LO  = (MAP_V_W+1)'(-SPR_HALF);
  localparam logic signed [MAP_V_W:0] SY_HI  = (MAP_V_W+1)'(SCR_H + SPR_HALF);

  logic [2:0]               state;
  logic                     c;
  logic signed [AW-1:0]     a;
  logic [AW-1:0]            r;
  logic [4:0]               q;
  logic [ANG_W-1:0]         ang2_q;
  logic [MAP_H_W-1:0]       x1_q, x2_q;
  logic [MAP_V_W-1:0]       y1_q, y2_q;

  logic signed [MAP_H_W:0]  dx, sx_n;
  logic signed [MAP_V_W:0]  dy, sy_n;
  logic                     vis_n;
  logic [4:0]               dir_n;

  always_comb begin
    dx    = {x2_q[MAP_H_W-1], x2_q} - {x1_q[MAP_H_W-1], x1_q};
    dy    = {y2_q[MAP_V_W-1], y2_q} - {y1_q[MAP_V_W-1], y1_q};
    sx_n  = HALF_W + dx;
    // Map y grows upward, screen y grows downward.
    sy_n  = HALF_H - dy;
    vis_n = (sx_n > SX_LO) && (sx_n < SX_HI) && (sy_n > SY_LO) && (sy_n < SY_HI);
    dir_n = (q == 5'd24) ? '0 : q;
  end

  assign o_valid = (state == S_OUT);
  assign o_busy  = (state != S_IDLE);

  always_ff @(posedge i_render_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      c          <= 1'b0;
      a          <= '0;
      r          <= '0;
      q          <= '0;
      ang2_q     <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      x2_q       <= '0;
      y2_q       <= '0;
      o_car1_dir <= '0;
      o_car2_dir <= '0;
      o_car2_sx  <= '0;
      o_car2_sy  <= '0;
      o_car2_vis <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      o_drop <= i_frame_start && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (i_frame_start) begin
            c     <= 1'b0;
            state <= S_LATCH;
          end
        end
        S_LATCH: begin
          ang2_q <= i_car2_angle;
          x1_q   <= i_car1_x;
          y1_q   <= i_car1_y;
          x2_q   <= i_car2_x;
          y2_q   <= i_car2_y;
          a      <= {{2{i_car1_angle[ANG_W-1]}}, i_car1_angle};
          state  <= S_NORM;
        end
        S_NORM: begin
          if (a[AW-1]) begin
            a <= a + A360;
          end else if (a >= A360) begin
            a <= a - A360;
          end else begin
            r     <= a + A7;
            q     <= '0;
            state <= S_DIV;
          end
        end
        S_DIV: begin
          if (r >= R15) begin
            r <= r - R15;
            q <= q + 5'd1;
          end else if (!c) begin
            o_car1_dir <= dir_n;
            c          <= 1'b1;
            a          <= {{2{ang2_q[ANG_W-1]}}, ang2_q};
            state      <= S_NORM;
          end else begin
            o_car2_dir <= dir_n;
            state      <= S_POS;
          end
        end
        S_POS: begin
          o_car2_sx  <= sx_n;
          o_car2_sy  <= sy_n;
          o_car2_vis <= vis_n;
          state      <= S_OUT;
        end
        S_OUT: begin
          if (i_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_car_sprite_mapper.sv
// Scoreboard bench for car_sprite_mapper: expected records are queued at frame start and
// compared while o_valid is high, popped on acceptance.
module tb_car_sprite_mapper;

  localparam int ANG_W = 10;
  localparam int MHW   = 12;
  localparam int MVW   = 12;

  typedef struct {
    int d1;
    int d2;
    int sx;
    int sy;
    int vis;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             frame_start;
  logic [ANG_W-1:0] car1_angle, car2_angle;
  logic [MHW-1:0]   car1_x, car2_x;
  logic [MVW-1:0]   car1_y, car2_y;
  logic             ready;
  logic             valid, car2_vis, busy, drop;
  logic [4:0]       car1_dir, car2_dir;
  logic [MHW:0]     car2_sx;
  logic [MVW:0]     car2_sy;

  rec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;

  car_sprite_mapper #(
    .ANG_W(ANG_W), .MAP_H_W(MHW), .MAP_V_W(MVW),
    .SCR_W(640), .SCR_H(480), .SPR_HALF(32)
  ) dut (
    .i_render_clk (clk),
    .i_rst        (rst),
    .i_frame_start(frame_start),
    .i_car1_angle (car1_angle),
    .i_car2_angle (car2_angle),
    .i_car1_x     (car1_x),
    .i_car1_y     (car1_y),
    .i_car2_x     (car2_x),
    .i_car2_y     (car2_y),
    .i_ready      (ready),
    .o_valid      (valid),
    .o_car1_dir   (car1_dir),
    .o_car2_dir   (car2_dir),
    .o_car2_sx    (car2_sx),
    .o_car2_sy    (car2_sy),
    .o_car2_vis   (car2_vis),
    .o_busy       (busy),
    .o_drop       (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sprite direction of one angle plus the NORM+DIV cycles spent on it.
  function automatic int model_dir(input int ang, output int ncyc);
    int a = ang;
    int n = 1;
    int q;
    while (a < 0)    begin a += 360; n++; end
    while (a >= 360) begin a -= 360; n++; end
    q = (a + 7) / 15;
    ncyc = n + q + 1;
    return (q == 24) ? 0 : q;
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        check("dir1", int'(car1_dir), sb[0].d1);
        check("dir2", int'(car2_dir), sb[0].d2);
        check("sx",   int'($signed(car2_sx)), sb[0].sx);
        check("sy",   int'($signed(car2_sy)), sb[0].sy);
        check("vis",  int'(car2_vis), sb[0].vis);
        if (ready) begin
          void'(sb.pop_front());
          n_acc++;
        end
      end
    end
  end

  task automatic drive_pose(input int a1, input int a2, input int x1, input int y1,
                            input int x2, input int y2);
    car1_angle = ANG_W'(a1);
    car2_angle = ANG_W'(a2);
    car1_x = MHW'(x1);
    car1_y = MVW'(y1);
    car2_x = MHW'(x2);
    car2_y = MVW'(y2);
  endtask

  // Pushes the expected record, pulses frame start, and checks the latency to o_valid.
  task automatic run_frame(input int a1, input int a2, input int x1, input int y1,
                           input int x2, input int y2);
    rec_t e;
    int c1, c2, lat;
    int dx = x2 - x1;
    int dy = y2 - y1;
    e.d1  = model_dir(a1, c1);
    e.d2  = model_dir(a2, c2);
    e.sx  = 320 + dx;
    e.sy  = 240 - dy;
    e.vis = (e.sx > -32 && e.sx < 672 && e.sy > -32 && e.sy < 512) ? 1 : 0;
    sb.push_back(e);
    drive_pose(a1, a2, x1, y1, x2, y2);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    lat = 1;
    while (!valid && lat < 200) begin
      tick();
      lat++;
      if (lat == 2) drive_pose($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    end
    check("latency", lat, 1 + c1 + c2 + 1 + 1);
  endtask

  task automatic drain();
    int n = 0;
    while (valid && n < 50) begin tick(); n++; end
    check("drained", int'(valid), 0);
  endtask

  initial begin
    int sweep[8] = '{7, 8, 352, 353, -15, -360, 511, -512};
    int drops, acc0, spur;

    rst = 1'b1;
    frame_start = 1'b0;
    ready = 1'b1;
    drive_pose(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("rst_valid", int'(valid), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_drop",  int'(drop), 0);
    check("rst_dir1",  int'(car1_dir), 0);
    check("rst_sx",    int'(car2_sx), 0);
    check("rst_vis",   int'(car2_vis), 0);
    rst = 1'b0;
    tick();

    run_frame(60, 120, 0, 250, 650, -250);
    drain();

    foreach (sweep[i]) begin
      run_frame(sweep[i], 0, 0, 0, 0, 0);
      drain();
    end

    run_frame(0, 0, 100, 100, 100, 100);  drain();
    run_frame(0, 0, 0, 0, -351, 0);       drain();
    run_frame(0, 0, 0, 0, -352, 0);       drain();
    run_frame(90, 270, 0, 0, 0, 271);     drain();
    run_frame(180, 45, 0, 0, 0, -272);    drain();

    // Stalled renderer with an extra frame start that must be dropped.
    ready = 1'b0;
    run_frame(-15, 353, 10, 20, -30, 40);
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      if (drop) drops++;
    end
    check("drop_count", drops, 1);
    check("hold_valid", int'(valid), 1);
    acc0 = n_acc;
    ready = 1'b1;
    drain();
    repeat (30) tick();
    check("accept_count", n_acc - acc0, 1);

    // Frame start coinciding with acceptance is dropped too.
    run_frame(30, 200, 5, 5, 5, 5);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("drop_on_accept", int'(drop), 1);
    check("idle_after_accept", int'(busy), 0);

    // Reset in the middle of DIV.
    drive_pose(359, 359, 1, 2, 3, 4);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (4) tick();
    check("busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy",  int'(busy), 0);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_dir1",  int'(car1_dir), 0);
    check("mid_rst_sx",    int'(car2_sx), 0);
    check("mid_rst_sy",    int'(car2_sy), 0);
    check("mid_rst_vis",   int'(car2_vis), 0);
    spur = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (valid) spur++;
    end
    check("no_valid_after_rst", spur, 0);

    run_frame(60, 120, 0, 250, 650, -250);
    drain();
    repeat (3) tick();
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
